// File: rtl/pwr_cntr_sched_if.sv
// pwr_cntr_sched_if: valid/ready port carrying each captured power count and its address
//   OUT_DATA  captured count (master drives)
//   OUT_DIR   counter address of OUT_DATA (master drives)
//   OUT_VALID OUT_DATA/OUT_DIR valid (master drives)
//   OUT_READY consumer accepts (slave drives)
interface pwr_cntr_sched_if #(
  parameter int CNTR_W = 32,
  parameter int DIR_W = 2
);
  logic [CNTR_W-1:0] OUT_DATA;
  logic [DIR_W-1:0] OUT_DIR;
  logic OUT_VALID;
  logic OUT_READY;
  modport master (output OUT_DATA, OUT_DIR, OUT_VALID, input OUT_READY);
  modport slave (input OUT_DATA, OUT_DIR, OUT_VALID, output OUT_READY);
endinterface

// File: rtl/pwr_cntr_sched.sv
// pwr_cntr_sched: sweeps the shared power-counter bus, presents each count on a valid/ready port and keeps a saturating total
//   CLK, RESET_L  clock, asynchronous active-low reset
//   ENB, START    block enable (low aborts a sweep), sweep request sampled in IDLE
//   dato          shared counter bus, valid while LE=0
//   dir, LE, CLR  counter address, active-low output enable, clear-on-read strobe
//   o             captured count / address output port (valid/ready)
//   SUM, BUSY, DONE  saturating sweep total, sweep in progress, completion pulse
//   Macro PWR_CLR_ON_READ_EN: pulse CLR after each capture so counters restart from 0
module pwr_cntr_sched #(
  parameter int NUM_CNTR = 3,
  parameter int CNTR_W = 32,
  parameter int DIR_W = 2
) (
  input  logic CLK,
  input  logic RESET_L,
  input  logic ENB,
  input  logic START,
  input  logic [CNTR_W-1:0] dato,
  output logic [DIR_W-1:0] dir,
  output logic LE,
  output logic CLR,
  output logic [CNTR_W-1:0] SUM,
  output logic BUSY,
  output logic DONE,
  pwr_cntr_sched_if.master o
);
  typedef enum logic [1:0] {IDLE, ADDR, PRESENT, FIN} state_t;
  localparam logic [DIR_W-1:0] LAST = DIR_W'(NUM_CNTR - 1);
  state_t state;
  logic [CNTR_W:0] acc;
  assign acc = {1'b0, SUM} + {1'b0, dato};
  always_ff @(posedge CLK or negedge RESET_L)
    if (!RESET_L) begin
      state <= IDLE;
      dir <= '0;
      LE <= 1'b1;
      o.OUT_DATA <= '0;
      o.OUT_DIR <= '0;
      o.OUT_VALID <= 1'b0;
      SUM <= '0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state != IDLE && !ENB) begin
        state <= IDLE;
        LE <= 1'b1;
        o.OUT_VALID <= 1'b0;
        BUSY <= 1'b0;
        dir <= '0;
      end else
        case (state)
          IDLE:
            if (ENB && START) begin
              state <= ADDR;
              dir <= '0;
              LE <= 1'b0;
              BUSY <= 1'b1;
              SUM <= '0;
            end
          ADDR: begin
            state <= PRESENT;
            o.OUT_DATA <= dato;
            o.OUT_DIR <= dir;
            o.OUT_VALID <= 1'b1;
            SUM <= acc[CNTR_W] ? '1 : acc[CNTR_W-1:0];
            LE <= 1'b1;
          end
          PRESENT:
            if (o.OUT_VALID && o.OUT_READY) begin
              o.OUT_VALID <= 1'b0;
              if (dir == LAST) begin
                state <= FIN;
                DONE <= 1'b1;
              end else begin
                state <= ADDR;
                dir <= dir + DIR_W'(1);
                LE <= 1'b0;
              end
            end
          FIN: begin
            state <= IDLE;
            BUSY <= 1'b0;
            dir <= '0;
          end
          default: state <= IDLE;
        endcase
    end
`ifdef PWR_CLR_ON_READ_EN
  // dir is unchanged through the first PRESENT cycle, so the strobe hits the counter just captured
  always_ff @(posedge CLK or negedge RESET_L)
    if (!RESET_L) CLR <= 1'b0;
    else CLR <= state == ADDR && ENB;
`else
  assign CLR = 1'b0;
`endif
endmodule

// File: tb/tb_pwr_cntr_sched.sv
// tb_pwr_cntr_sched: randomized self-checking bench for pwr_cntr_sched against a sweep-level reference model
module tb_pwr_cntr_sched;
  localparam int N = 3;
`ifdef PWR_CLR_ON_READ_EN
  localparam bit CLR_ON = 1'b1;
`else
  localparam bit CLR_ON = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RESET_L = 1'b0;
  logic ENB = 1'b0;
  logic START = 1'b0;
  logic [31:0] dato;
  logic [1:0] dir;
  logic LE, CLR, BUSY, DONE;
  logic [31:0] SUM;
  logic ld = 1'b0;
  logic [31:0] ld_v [4];
  logic [31:0] cnt [4];
  logic [31:0] model [4];
  int n_tests = 0;
  int n_fail = 0;
  pwr_cntr_sched_if #(.CNTR_W(32), .DIR_W(2)) bus ();
  pwr_cntr_sched #(.NUM_CNTR(N), .CNTR_W(32), .DIR_W(2)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .START(START), .dato(dato), .dir(dir),
    .LE(LE), .CLR(CLR), .SUM(SUM), .BUSY(BUSY), .DONE(DONE), .o(bus)
  );
  always #5 CLK = ~CLK;
  assign dato = LE ? 32'hDEAD_BEEF : cnt[dir];
  always @(posedge CLK)
    if (ld) for (int i = 0; i < 4; i++) cnt[i] <= ld_v[i];
    else if (CLR) cnt[dir] <= 32'h0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] sat(input logic [63:0] x);
    return x > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : x;
  endfunction
  task automatic load(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    ld_v[0] = a; ld_v[1] = b; ld_v[2] = c; ld_v[3] = 32'h0;
    for (int i = 0; i < 4; i++) model[i] = ld_v[i];
    ld = 1'b1;
    @(posedge CLK); #1;
    ld = 1'b0;
  endtask
  task automatic reset_vals();
    chk("rst_dir", dir, 0);
    chk("rst_le", LE, 1);
    chk("rst_clr", CLR, 0);
    chk("rst_data", bus.OUT_DATA, 0);
    chk("rst_odir", bus.OUT_DIR, 0);
    chk("rst_valid", bus.OUT_VALID, 0);
    chk("rst_sum", SUM, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
  endtask
  task automatic idle_chk(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK); #1;
      chk("idle_busy", BUSY, 0);
      chk("idle_le", LE, 1);
      chk("idle_valid", bus.OUT_VALID, 0);
    end
  endtask
  task automatic sweep(input bit rnd, input int stall_dir);
    logic [63:0] s;
    int e, stalls, got, le_n, clr_n, held;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("start_le", LE, 0);
    chk("start_dir", dir, 0);
    chk("start_busy", BUSY, 1);
    chk("start_sum", SUM, 0);
    chk("start_valid", bus.OUT_VALID, 0);
    s = 0; e = 0; stalls = 0; got = 0; clr_n = 0; held = 0;
    le_n = LE ? 0 : 1;
    while (!DONE && e < 400) begin
      if (stall_dir >= 0 && bus.OUT_VALID && bus.OUT_DIR == 2'(stall_dir) && held < 5) begin
        bus.OUT_READY = 1'b0;
        held++;
      end else bus.OUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) START = 1'($urandom_range(0, 1));
      if (bus.OUT_VALID && bus.OUT_READY) begin
        s = sat(s + 64'(model[got]));
        chk("out_dir", bus.OUT_DIR, got);
        chk("out_data", bus.OUT_DATA, model[got]);
        chk("sum", SUM, s);
        got++;
      end else if (bus.OUT_VALID) begin
        stalls++;
        chk("stall_le", LE, 1);
        chk("stall_dir", dir, got);
        chk("stall_data", bus.OUT_DATA, model[got]);
      end
      @(posedge CLK); #1;
      e++;
      if (!LE) le_n++;
      if (CLR) begin
        clr_n++;
        chk("clr_dir", dir, got);
      end
    end
    START = 1'b0;
    chk("done_edge", e, 2 * N + stalls);
    chk("xfers", got, N);
    chk("le_cycles", le_n, N);
    chk("clr_pulses", clr_n, CLR_ON ? N : 0);
    chk("done_sum", SUM, s);
    chk("done_busy", BUSY, 1);
    @(posedge CLK); #1;
    chk("fin_busy", BUSY, 0);
    chk("fin_done", DONE, 0);
    chk("fin_dir", dir, 0);
    chk("fin_sum", SUM, s);
    if (CLR_ON) for (int i = 0; i < N; i++) model[i] = 32'h0;
  endtask
  initial begin
    int w;
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin ld_v[i] = 32'h0; model[i] = 32'h0; end
    repeat (3) @(posedge CLK);
    #1;
    reset_vals();
    RESET_L = 1'b1;
    ENB = 1'b1;
    idle_chk(5);
    load(32'd10, 32'd20, 32'd30);
    sweep(1'b0, -1);
    sweep(1'b0, -1);
    load(32'd10, 32'd20, 32'd30);
    sweep(1'b0, 1);
    load(32'hFFFF_FFF0, 32'h20, 32'd5);
    sweep(1'b1, -1);
    load(32'd10, 32'd20, 32'd30);
    bus.OUT_READY = 1'b0;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    w = 0;
    while (!bus.OUT_VALID && w < 20) begin
      @(posedge CLK); #1;
      w++;
    end
    chk("abort_present", bus.OUT_DIR, 0);
    ENB = 1'b0;
    @(posedge CLK); #1;
    chk("abort_busy", BUSY, 0);
    chk("abort_le", LE, 1);
    chk("abort_valid", bus.OUT_VALID, 0);
    chk("abort_dir", dir, 0);
    chk("abort_sum", SUM, 10);
    if (CLR_ON) model[0] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_nodone", DONE, 0);
      @(posedge CLK); #1;
    end
    ENB = 1'b1;
    sweep(1'b0, -1);
    for (int r = 0; r < 4; r++) begin
      logic [31:0] v [3];
      for (int i = 0; i < 3; i++)
        v[i] = $urandom_range(0, 2) == 0 ? (32'hF000_0000 | $urandom) : $urandom_range(0, 5000);
      load(v[0], v[1], v[2]);
      sweep(1'b1, $urandom_range(0, 1) == 0 ? -1 : int'($urandom_range(0, 2)));
    end
    load(32'd7, 32'd8, 32'd9);
    bus.OUT_READY = 1'b0;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    chk("mid_valid", bus.OUT_VALID, 1);
    #2;
    RESET_L = 1'b0;
    #1;
    reset_vals();
    @(posedge CLK); #1;
    RESET_L = 1'b1;
    idle_chk(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
